// File: rtl/uart_tx_pkg.sv
// State encoding and frame-length helper shared by uart_tx and its bench.
// Parity support is compiled in when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    // Start + data + optional parity + stop.
    function automatic int frame_bits(input int data_width, input bit parity_en);
        return data_width + (parity_en ? 3 : 2);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Edge and bit counters for uart_tx: edge_count wraps every 2**PRESCALE_WIDTH
// enabled clocks, bit_count advances on each wrap. Independent of UART_TX_PARITY_EN.
module uart_tx_bit_timer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 4,
    parameter int BIT_CNT_WIDTH  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [BIT_CNT_WIDTH-1:0]  bit_count,
    output logic                      wrap
);

    assign wrap = enable && (edge_count == '1);

    // Clear has priority so the owner can re-align bit_count at a bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (clear) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (enable) begin
            edge_count <= edge_count + PRESCALE_WIDTH'(1);
            if (wrap) begin
                bit_count <= bit_count + BIT_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop; idle-high line.
// Define UART_TX_PARITY_EN to add the par_typ port and the parity bit.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
`ifdef UART_TX_PARITY_EN
    input  logic                  par_typ,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      tx_d;
    logic                      accept;
    logic                      start_last;
    logic                      timer_clear;
    logic [PRESCALE_WIDTH-1:0] edge_count;
    logic [BIT_CNT_WIDTH-1:0]  bit_count;
    logic                      wrap;

`ifdef UART_TX_PARITY_EN
    logic par_typ_q;
    logic parity_bit;

    assign parity_bit = (^data_q) ^ par_typ_q;
`endif

    assign accept = in_valid && in_ready;
    assign busy   = (state_q != IDLE);

    // Restart the bit counter as the start bit ends so data bit 0 sees bit_count 0.
    assign start_last  = (state_q == START) && (edge_count == '1);
    assign timer_clear = (state_q == IDLE) || start_last;

    uart_tx_bit_timer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (busy),
        .clear      (timer_clear),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .wrap       (wrap)
    );

    // tx_d is the line level for the state being entered, so tx_out stays a pure flop.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_out;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (start_last) begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_count == BIT_CNT_WIDTH'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_bit;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = data_q[bit_count + BIT_CNT_WIDTH'(1)];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_out    <= 1'b1;
            in_ready  <= 1'b0;
            data_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_typ_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tx_out   <= tx_d;
            in_ready <= (state_d == IDLE);
            if (accept) begin
                data_q    <= in_data;
`ifdef UART_TX_PARITY_EN
                par_typ_q <= par_typ;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (DATA_WIDTH=8, 16 clocks per bit).
// Builds with or without UART_TX_PARITY_EN; expected frames follow the build.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int DW       = 8;
    localparam int PW       = 4;
    localparam int BIT_CLKS = 2 ** PW;
    localparam int FRAME    = frame_bits(DW, PARITY_EN);
    localparam int PERIOD   = FRAME * BIT_CLKS + 1;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          tx_out;
    logic          busy;
`ifdef UART_TX_PARITY_EN
    logic          par_typ  = 1'b0;
`endif

    int checks = 0;
    int passes = 0;

    uart_tx #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef UART_TX_PARITY_EN
        .par_typ  (par_typ),
`endif
        .tx_out   (tx_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Line level of frame bit idx: 0 start, 1..DW data LSB first, then parity/stop.
    function automatic logic expected_bit(input logic [DW-1:0] d, input logic pt, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (PARITY_EN && idx == DW + 1) return (^d) ^ pt;
        return 1'b1;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL %s ready_timeout in_ready=%b required 1", name, in_ready);
        else passes++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) $display("[TB] FAIL reset_tx tx_out=%b required 1", tx_out);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy busy=%b required 0", busy);
        else passes++;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_ready in_ready=%b required 0", in_ready);
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL release_ready in_ready=%b required 0 before edge", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL first_edge_ready in_ready=%b required 1", in_ready);
        else passes++;
    endtask

    // Sends d; one cycle after the accept the inputs change to alt / ~pt.
    task automatic test_frame(input string name, input logic [DW-1:0] d, input logic pt, input logic [DW-1:0] alt);
        int   busy_clks;
        logic ok;
        logic bad;
        busy_clks = 0;
        @(negedge clk);
        wait_ready(name);
        in_data = d;
`ifdef UART_TX_PARITY_EN
        par_typ = pt;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = alt;
`ifdef UART_TX_PARITY_EN
        par_typ = ~pt;
`endif
        for (int b = 0; b < FRAME; b++) begin
            ok  = 1'b1;
            bad = 1'b0;
            for (int s = 0; s < BIT_CLKS; s++) begin
                if (tx_out !== expected_bit(d, pt, b)) begin
                    ok  = 1'b0;
                    bad = tx_out;
                end
                if (busy === 1'b1) busy_clks++;
                @(negedge clk);
            end
            checks++;
            if (!ok) $display("[TB] FAIL %s bit%0d tx_out=%b required %b for %0d clocks",
                              name, b, bad, expected_bit(d, pt, b), BIT_CLKS);
            else passes++;
        end
        checks++;
        if (busy_clks != FRAME * BIT_CLKS)
            $display("[TB] FAIL %s busy_len busy_clocks=%0d required %0d", name, busy_clks, FRAME * BIT_CLKS);
        else passes++;
        checks++;
        if ({busy, in_ready, tx_out} !== 3'b011)
            $display("[TB] FAIL %s end_state busy/ready/tx=%b%b%b required 011", name, busy, in_ready, tx_out);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int   rdy_cnt;
        logic ok1;
        logic ok2;
        rdy_cnt = 0;
        ok1     = 1'b1;
        ok2     = 1'b1;
        @(negedge clk);
        wait_ready("b2b");
        in_data = 8'h00;
`ifdef UART_TX_PARITY_EN
        par_typ = 1'b0;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'hFF;
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) rdy_cnt++;
            if ((c % BIT_CLKS) == BIT_CLKS / 2 && (c / BIT_CLKS) < FRAME &&
                tx_out !== expected_bit(8'h00, 1'b0, c / BIT_CLKS)) ok1 = 1'b0;
            if (c == PERIOD - 1) begin
                checks++;
                if ({in_ready, tx_out} !== 2'b11)
                    $display("[TB] FAIL b2b_gap ready/tx=%b%b required 11", in_ready, tx_out);
                else passes++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (rdy_cnt != 1) $display("[TB] FAIL b2b_ready_cycles count=%0d required 1", rdy_cnt);
        else passes++;
        checks++;
        if (!ok1) $display("[TB] FAIL b2b_frame0 tx_out=%b required 0x00 frame bits", ok1);
        else passes++;
        checks++;
        if ({busy, tx_out} !== 2'b10)
            $display("[TB] FAIL b2b_second_start busy/tx=%b%b required 10 at clock %0d", busy, tx_out, PERIOD);
        else passes++;
        for (int i = 0; i < FRAME; i++) begin
            repeat (BIT_CLKS / 2) @(negedge clk);
            if (tx_out !== expected_bit(8'hFF, 1'b0, i)) ok2 = 1'b0;
            repeat (BIT_CLKS / 2) @(negedge clk);
        end
        checks++;
        if (!ok2) $display("[TB] FAIL b2b_frame1 tx_out=%b required 0xFF frame bits", ok2);
        else passes++;
        checks++;
        if ({busy, in_ready} !== 2'b01)
            $display("[TB] FAIL b2b_end busy/ready=%b%b required 01", busy, in_ready);
        else passes++;
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        wait_ready("mid_rst");
        in_data = 8'h3C;
`ifdef UART_TX_PARITY_EN
        par_typ = 1'b0;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (39) @(negedge clk);
        checks++;
        if (tx_out !== 1'b0) $display("[TB] FAIL mid_rst_pre tx_out=%b required 0 (data bit1 of 0x3C)", tx_out);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_out, busy, in_ready} !== 3'b100)
            $display("[TB] FAIL mid_rst_async tx/busy/ready=%b%b%b required 100", tx_out, busy, in_ready);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL mid_rst_release in_ready=%b required 0", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL mid_rst_first_edge in_ready=%b required 1", in_ready);
        else passes++;
        test_frame("after_rst_3c", 8'h3C, 1'b0, 8'h3C);
    endtask

    initial begin
        test_reset();
        test_frame("even_a5", 8'hA5, 1'b0, 8'hA5);
        test_frame("odd_a5", 8'hA5, 1'b1, 8'hA5);
        test_back_to_back();
        test_reset_mid_frame();
        test_frame("latch_11", 8'h11, 1'b0, 8'hEE);
        test_frame("frame_81", 8'h81, 1'b0, 8'h81);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 Parameter PRESCALE_WIDTH, default 4: each bit lasts 2**PRESCALE_WIDTH clocks, matching the receiver's oversampling edge count.
REQ-003 Port clk  input  1  single clock; all state updates on posedge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_data  input  DATA_WIDTH  payload to transmit.
REQ-006 Port in_valid  input  1  in_data valid.
REQ-007 Port in_ready  output  1  block can accept a byte this cycle.
REQ-008 Port par_typ  input  1  0 = even parity, 1 = odd parity; present only with UART_TX_PARITY_EN.
REQ-009 Port tx_out  output  1  serial line, idle high.
REQ-010 Port busy  output  1  frame in progress.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; the state SHALL be IDLE out of reset.
REQ-012 in_ready SHALL be registered, high only in IDLE, and low in the cycle after an accept.
REQ-013 An accept SHALL occur on a rising edge where in_valid && in_ready; in_data and par_typ SHALL be latched there, and later input changes SHALL not affect the frame.
REQ-014 On accept: IDLE->START; from the next cycle tx_out=0 and busy=1.
REQ-015 Every bit (start, data, parity, stop) SHALL hold tx_out for exactly 2**PRESCALE_WIDTH clocks, timed by an edge counter that wraps from all-ones to 0.
REQ-016 Data bits SHALL be sent LSB first; a bit counter of width $clog2(DATA_WIDTH) SHALL advance on edge-counter wrap and leave DATA after bit DATA_WIDTH-1.
REQ-017 The parity bit SHALL be the XOR of the latched data, inverted when par_typ=1.
REQ-018 The stop bit SHALL be tx_out=1.
REQ-019 After the last stop-bit clock the state SHALL be IDLE, with busy=0 and in_ready=1 in the same cycle.
REQ-020 With in_valid held high, frames SHALL be back to back with a period of (frame bits)*2**PRESCALE_WIDTH + 1 clocks; tx_out SHALL stay 1 during the gap cycle.
REQ-021 tx_out SHALL be driven from a flop with no combinational path from any input.
REQ-022 in_valid while in_ready=0 SHALL be ignored without side effects (no queuing).

Reset
REQ-023 While rst=1: tx_out=1, busy=0, in_ready=0, state IDLE, edge and bit counters 0, latched data 0.
REQ-024 rst asserted mid-frame SHALL abort the frame immediately (asynchronously), with tx_out returning to 1.
REQ-025 in_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: port par_typ and state PARITY exist; the frame is 1+DATA_WIDTH+1+1 bits.
REQ-027 Macro UART_TX_PARITY_EN undefined: port par_typ and state PARITY are absent; DATA goes directly to STOP; the frame is DATA_WIDTH+2 bits.

Structure
REQ-028 Package uart_tx_pkg SHALL hold the state encoding constants and the frame-length function of DATA_WIDTH and the parity option.
REQ-029 The edge and bit counting SHALL be one sub-module, uart_tx_bit_timer: enable and clear inputs; edge_count, bit_count and wrap pulse outputs.

Verification (DATA_WIDTH=8, PRESCALE_WIDTH=4, 16 clk/bit)
REQ-030 Parity on, par_typ=0, send 0xA5 -> tx_out: 0 for 16 clocks, then 1,0,1,0,0,1,0,1 (16 each), parity 0, stop 1; busy high for 176 clocks.
REQ-031 Parity on, par_typ=1, send 0xA5 -> parity bit 1; all other bits identical to REQ-030.
REQ-032 in_valid held high with 0x00 then 0xFF -> second start bit begins 177 clocks after the first; in_ready high for exactly 1 cycle between frames.
REQ-033 rst pulsed at clock 40 of a frame -> tx_out=1 and busy=0 without waiting for clk; in_ready=1 on the first edge after release; the next accepted 0x3C is sent correctly.
REQ-034 Change in_data from 0x11 to 0xEE one cycle after accepting 0x11 -> 0x11 is transmitted.
REQ-035 Parity off, send 0x81 -> 10-bit frame, 160 clocks, stop bit immediately after data bit 7.
